sync_fifo_burst_reader: RTL and testbench

Read-side consumer for the team's `sync_fifo`. It watches the FIFO fill level and, once a full burst is buffered, drains exactly `BURST_LEN` words. The words go out on a valid/ready stream with start/end-of-burst markers. It sits between the FIFO read port and any downstream packet consumer, and decouples downstream backpressure from the FIFO through a 3-entry output buffer.

---
 rtl/sync_fifo_burst_reader.sv | 156 +++++++++++++++
 tb/tb_sync_fifo_burst_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_burst_reader.sv
// Burst reader for sync_fifo: waits for BURST_LEN buffered words, then drains exactly one
// burst onto a valid/ready stream with sop/eop tags through a 3-entry skid buffer.
module sync_fifo_burst_reader #(
    parameter int DATA_SIZE  = 8,
    parameter int DATA_DEPTH = 16,
    parameter int APT_SIZE   = $clog2(DATA_DEPTH),
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    output logic                  fifo_rd_o,
    input  logic [DATA_SIZE-1:0]  fifo_dout_i,
    input  logic                  fifo_empty_i,
    input  logic [APT_SIZE:0]     fifo_usedw_i,
    output logic [DATA_SIZE-1:0]  out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_sop_o,
    output logic                  out_eop_o,
    output logic                  busy_o,
    output logic [15:0]           burst_cnt_o
);

    localparam int ISS_W = $clog2(BURST_LEN) + 1;
    localparam logic [APT_SIZE:0] BURST_LEN_U = (APT_SIZE + 1)'(BURST_LEN);
    localparam logic [ISS_W-1:0]  BURST_LEN_I = ISS_W'(BURST_LEN);
    localparam logic [ISS_W-1:0]  LAST_IDX    = ISS_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_SIZE-1:0] data;
        logic                 sop;
        logic                 eop;
    } beat_t;

    state_t             state_q, state_d;
    logic [ISS_W-1:0]   issued_q, issued_d;
    logic               inflight_q, inflight_d;
    logic               inflight_sop_q, inflight_sop_d;
    logic               inflight_eop_q, inflight_eop_d;
    beat_t [2:0]        buf_q, buf_d;
    logic [2:0]         vld_q, vld_d;
    logic               busy_q, busy_d;
    logic [15:0]        burst_cnt_q, burst_cnt_d;

    logic  credit_ok;
    logic  rd;
    logic  pop;
    logic  placed;
    beat_t entry;

    // Stream handshake: a beat transfers on any edge where out_valid_o && out_ready_i;
    // while valid is high and ready low, data/sop/eop stay frozen on the head entry.
    assign pop = vld_q[0] && out_ready_i;

    // Credit uses only registered occupancy plus the in-flight read, so out_ready_i
    // never reaches the read strobe combinationally.
    assign credit_ok = inflight_q ? !vld_q[1] : !vld_q[2];
    assign rd        = (state_q == BURST) && !fifo_empty_i && credit_ok;

    always_comb begin
        state_d        = state_q;
        issued_d       = issued_q;
        burst_cnt_d    = burst_cnt_q;
        inflight_d     = rd;
        inflight_sop_d = (issued_q == '0);
        inflight_eop_d = (issued_q == LAST_IDX);

        case (state_q)
            IDLE: begin
                if (enable_i && (fifo_usedw_i >= BURST_LEN_U)) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (rd) begin
                    issued_d = issued_q + ISS_W'(1);
                    if (issued_d == BURST_LEN_I) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && buf_q[0].eop) begin
                    state_d     = IDLE;
                    issued_d    = '0;
                    burst_cnt_d = burst_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // Shift-down buffer: entry 0 is always the head, so the outputs come straight off flops.
    always_comb begin
        buf_d  = buf_q;
        vld_d  = vld_q;
        placed = 1'b0;
        entry  = '{data: fifo_dout_i, sop: inflight_sop_q, eop: inflight_eop_q};

        if (pop) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
            vld_d    = {1'b0, vld_q[2:1]};
        end

        for (int i = 0; i < 3; i++) begin
            if (inflight_q && !placed && !vld_d[i]) begin
                buf_d[i] = entry;
                vld_d[i] = 1'b1;
                placed   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            issued_q       <= '0;
            inflight_q     <= 1'b0;
            inflight_sop_q <= 1'b0;
            inflight_eop_q <= 1'b0;
            buf_q          <= '0;
            vld_q          <= '0;
            busy_q         <= 1'b0;
            burst_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            issued_q       <= issued_d;
            inflight_q     <= inflight_d;
            inflight_sop_q <= inflight_sop_d;
            inflight_eop_q <= inflight_eop_d;
            buf_q          <= buf_d;
            vld_q          <= vld_d;
            busy_q         <= busy_d;
            burst_cnt_q    <= burst_cnt_d;
        end
    end

    assign fifo_rd_o   = rd;
    assign out_data_o  = buf_q[0].data;
    assign out_sop_o   = buf_q[0].sop;
    assign out_eop_o   = buf_q[0].eop;
    assign out_valid_o = vld_q[0];
    assign busy_o      = busy_q;
    assign burst_cnt_o = burst_cnt_q;

endmodule

// File: tb/tb_sync_fifo_burst_reader.sv
// Directed bench for sync_fifo_burst_reader with a 1-cycle-latency FIFO model,
// a negedge beat/read monitor and an expected-beat queue.
module tb_sync_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fifo_rd;
    logic [7:0]  fifo_dout = '0;
    logic        fifo_empty;
    logic [4:0]  fifo_usedw;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic        busy;
    logic [15:0] burst_cnt;

    sync_fifo_burst_reader #(
        .DATA_SIZE (8),
        .DATA_DEPTH(16),
        .APT_SIZE  (4),
        .BURST_LEN (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .fifo_rd_o   (fifo_rd),
        .fifo_dout_i (fifo_dout),
        .fifo_empty_i(fifo_empty),
        .fifo_usedw_i(fifo_usedw),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sop_o   (out_sop),
        .out_eop_o   (out_eop),
        .busy_o      (busy),
        .burst_cnt_o (burst_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    // FIFO model: read data appears the cycle after the strobe
    logic [7:0] fmem [0:255];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int cyc = 0;

    assign fifo_usedw = 5'(wr_cnt - rd_cnt);
    assign fifo_empty = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd) begin
            fifo_dout <= fmem[rd_cnt[7:0]];
            rd_cnt    <= rd_cnt + 1;
        end
    end

    // monitor
    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       e;
        int         c;
    } mon_t;

    mon_t beats[$];
    int   rd_cyc[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) beats.push_back('{out_data, out_sop, out_eop, cyc});
            if (fifo_rd) rd_cyc.push_back(cyc);
        end
    end

    // scoreboard
    logic [9:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int beat_cyc(input int i);
        return (i < beats.size()) ? beats[i].c : -1;
    endfunction

    function automatic int rd_at(input int i);
        return (i < rd_cyc.size()) ? rd_cyc[i] : -1;
    endfunction

    task automatic check_stream(input string tag, input int first_cyc);
        logic [9:0] got;
        check({tag, " beat_count"}, beats.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < beats.size()) got = {beats[i].d, beats[i].s, beats[i].e};
            else got = 'x;
            check({tag, " beat"}, got, exp_q[i]);
            if (first_cyc >= 0) check({tag, " beat_cyc"}, beat_cyc(i), first_cyc + i);
        end
    endtask

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        beats.delete();
        rd_cyc.delete();
        exp_q.delete();
    endtask

    task automatic load(input logic [7:0] d);
        fmem[wr_cnt[7:0]] = d;
        wr_cnt++;
    endtask

    task automatic expect_burst(input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3);
        exp_q.push_back({d0, 2'b10});
        exp_q.push_back({d1, 2'b00});
        exp_q.push_back({d2, 2'b00});
        exp_q.push_back({d3, 2'b01});
    endtask

    int start;

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b0;
        step(2);
        check("reset_outputs", {out_valid, out_sop, out_eop, busy, fifo_rd, out_data, burst_cnt}, 32'h0);

        rst = 1'b0;
        step(10);
        check("idle_no_read", rd_cyc.size(), 0);
        check("idle_busy", busy, 1'b0);

        // single burst, ready held high
        out_ready = 1'b1;
        clear_mon();
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        step(1);
        enable = 1'b1;
        start  = cyc;
        expect_burst(8'h11, 8'h22, 8'h33, 8'h44);
        step(6);
        check("single busy_in_drain", busy, 1'b1);
        step(1);
        check("single busy_after_eop", busy, 1'b0);
        step(3);
        check("single rd_count", rd_cyc.size(), 4);
        check("single rd_first", rd_at(0), start + 1);
        check("single rd_last", rd_at(3), start + 4);
        check_stream("single", start + 3);
        check("single burst_cnt", burst_cnt, 16'd1);

        // below threshold, then the 4th word arrives
        clear_mon();
        load(8'hA0); load(8'hA1); load(8'hA2);
        step(20);
        check("thresh no_read", rd_cyc.size(), 0);
        check("thresh busy", busy, 1'b0);
        load(8'hA3);
        start = cyc;
        expect_burst(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        step(10);
        check_stream("thresh", start + 3);
        check("thresh burst_cnt", burst_cnt, 16'd2);

        // backpressure from the first beat for 6 cycles
        enable    = 1'b0;
        out_ready = 1'b0;
        clear_mon();
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        step(1);
        enable = 1'b1;
        start  = cyc;
        expect_burst(8'h11, 8'h22, 8'h33, 8'h44);
        step(3);
        for (int i = 0; i < 6; i++) begin
            check("bp hold_head", {out_valid, out_sop, out_data}, {1'b1, 1'b1, 8'h11});
            step(1);
        end
        check("bp reads_while_stalled", rd_cyc.size(), 3);
        out_ready = 1'b1;
        step(8);
        check("bp rd_total", rd_cyc.size(), 4);
        check_stream("bp", start + 9);
        check("bp burst_cnt", burst_cnt, 16'd3);

        // back-to-back bursts from 8 buffered words
        enable = 1'b0;
        clear_mon();
        for (int i = 0; i < 8; i++) load(8'(i));
        step(1);
        enable = 1'b1;
        start  = cyc;
        expect_burst(8'h00, 8'h01, 8'h02, 8'h03);
        expect_burst(8'h04, 8'h05, 8'h06, 8'h07);
        step(16);
        check_stream("b2b", -1);
        check("b2b first_beat_cyc", beat_cyc(0), start + 3);
        check("b2b second_sop_cyc", beat_cyc(4), start + 10);
        check("b2b rd_total", rd_cyc.size(), 8);
        check("b2b burst_cnt", burst_cnt, 16'd5);

        // enable dropped after beat 1: first burst finishes, second never starts
        enable = 1'b0;
        clear_mon();
        for (int i = 0; i < 8; i++) load(8'h80 + 8'(i));
        step(1);
        enable = 1'b1;
        start  = cyc;
        expect_burst(8'h80, 8'h81, 8'h82, 8'h83);
        step(5);
        enable = 1'b0;
        step(15);
        check_stream("en_drop", start + 3);
        check("en_drop burst_cnt", burst_cnt, 16'd6);
        check("en_drop busy", busy, 1'b0);
        check("en_drop usedw_left", fifo_usedw, 5'd4);
        wr_cnt = rd_cnt;

        // asynchronous reset mid-burst after two accepted beats
        enable = 1'b1;
        clear_mon();
        load(8'h51); load(8'h52); load(8'h53); load(8'h54);
        step(5);
        check("mid_rst accepted_before", beats.size(), 2);
        check("mid_rst head_before", {out_valid, out_data}, {1'b1, 8'h53});
        #2 rst = 1'b1;
        #1;
        check("mid_rst outputs", {out_valid, out_sop, out_eop, busy, fifo_rd, out_data, burst_cnt}, 32'h0);
        step(1);
        wr_cnt = rd_cnt;
        rst = 1'b0;
        clear_mon();
        load(8'h61); load(8'h62); load(8'h63); load(8'h64);
        start = cyc;
        expect_burst(8'h61, 8'h62, 8'h63, 8'h64);
        step(10);
        check_stream("after_rst", start + 3);
        check("after_rst burst_cnt", burst_cnt, 16'd1);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
